// File: rtl/tt_io_tester_pkg.sv
// rtl/tt_io_tester_pkg.sv - shared mode encoding for the pad exerciser
//
// Purpose: test-mode enumeration and width shared by tt_io_tester.
// Ports:   none (package).

package tt_io_tester_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_PASS  = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_LOOP  = 2'd2,
        MODE_WALK  = 2'd3
    } mode_e;

endpackage

// File: rtl/tt_sync_bus.sv
// rtl/tt_sync_bus.sv - WIDTH x STAGES flop synchroniser
//
// Purpose: multi-stage synchroniser for an asynchronous input bus.
// Ports:
//   clk    in  1      system clock
//   rst_n  in  1      asynchronous active-low reset, clears every stage
//   d      in  WIDTH  asynchronous input bus
//   q      out WIDTH  synchronised bus (last stage)

module tt_sync_bus #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/tt_io_tester.sv
// rtl/tt_io_tester.sv - mode-selectable pad exerciser for the tile top level
//
// Purpose: synchronises ui_in/uio_in and drives registered outputs in one of
//   four test modes (PASS, COUNT, LOOP, WALK) chosen by ui_in[IO_W-1:IO_W-2];
//   a prescaled clock is driven on uio_out[0] in PASS and WALK.
// Optional: define TT_IO_TESTER_PARITY_EN to replace uo_out[IO_W-1] in LOOP
//   mode with the even-parity bit of s_uio[IO_W-2:0].
// Ports:
//   clk      in  1     system clock
//   rst_n    in  1     asynchronous active-low reset
//   ena      in  1     enable; 0 freezes counter, prescaler, walker, clkdiv
//   ui_in    in  IO_W  dedicated inputs, top two bits select the mode
//   uio_in   in  IO_W  bidir input path
//   uo_out   out IO_W  dedicated outputs (registered)
//   uio_out  out IO_W  bidir outputs (registered)
//   uio_oe   out IO_W  bidir output enables, 1 = drive (registered)

module tt_io_tester
    import tt_io_tester_pkg::*;
#(
    parameter int IO_W        = 8,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DIV_LOG2    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [IO_W-1:0] ui_in,
    input  logic [IO_W-1:0] uio_in,
    output logic [IO_W-1:0] uo_out,
    output logic [IO_W-1:0] uio_out,
    output logic [IO_W-1:0] uio_oe
);

    // A zero-width prescaler is kept as a single bit pinned at 0, so the
    // step strobe fires every cycle when DIV_LOG2 = 0.
    localparam int               PRE_W   = (DIV_LOG2 > 0) ? DIV_LOG2 : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'((1 << DIV_LOG2) - 1);
    localparam int               HI_W    = CNT_W - IO_W;

    logic [IO_W-1:0]  s_ui;
    logic [IO_W-1:0]  s_uio;
    mode_e            mode;
    mode_e            mode_q, mode_d;
    logic             mode_chg;
    logic             step;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             clkdiv_q, clkdiv_d;
    logic [IO_W-1:0]  walk_q, walk_d;
    logic [IO_W-1:0]  uo_q, uo_d;
    logic [IO_W-1:0]  uio_out_q, uio_out_d;
    logic [IO_W-1:0]  uio_oe_q, uio_oe_d;

    tt_sync_bus #(.WIDTH(IO_W), .STAGES(SYNC_STAGES)) u_sync_ui (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in),
        .q     (s_ui)
    );

    tt_sync_bus #(.WIDTH(IO_W), .STAGES(SYNC_STAGES)) u_sync_uio (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uio_in),
        .q     (s_uio)
    );

    assign mode = mode_e'(s_ui[IO_W-1 -: MODE_W]);

    // Generator state: a mode change restarts counter, prescaler and walker
    // and suppresses any increment or step in the same cycle.
    always_comb begin
        mode_chg = (mode != mode_q);
        step     = ena && (pre_q == PRE_MAX) && !mode_chg;
        mode_d   = mode;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        walk_d   = walk_q;
        clkdiv_d = clkdiv_q;
        if (mode_chg) begin
            cnt_d  = '0;
            pre_d  = '0;
            walk_d = IO_W'(1);
        end else if (ena) begin
            cnt_d = cnt_q + CNT_W'(1);
            pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
        end
        if (step) begin
            walk_d   = {walk_q[IO_W-2:0], walk_q[IO_W-1]};
            clkdiv_d = ~clkdiv_q;
        end
    end

    // Outputs load the generator's next-state values so the pads show the
    // same value the counter/walker registers take on this edge; a mode
    // change therefore presents 0x00 / 0x01 immediately.
    always_comb begin
        uo_d      = '0;
        uio_out_d = '0;
        uio_oe_d  = '0;
        case (mode)
            MODE_PASS: begin
                uo_d         = s_ui;
                uio_out_d[0] = clkdiv_d;
                uio_oe_d     = IO_W'(1);
            end
            MODE_COUNT: begin
                uo_d                 = cnt_d[IO_W-1:0];
                uio_out_d[HI_W-1:0]  = cnt_d[CNT_W-1:IO_W];
                uio_oe_d             = '1;
            end
            MODE_LOOP: begin
`ifdef TT_IO_TESTER_PARITY_EN
                uo_d = {^s_uio[IO_W-2:0], s_uio[IO_W-2:0]};
`else
                uo_d = s_uio;
`endif
            end
            MODE_WALK: begin
                uo_d         = walk_d;
                uio_out_d[0] = clkdiv_d;
                uio_oe_d     = IO_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_PASS;
            cnt_q     <= '0;
            pre_q     <= '0;
            clkdiv_q  <= 1'b0;
            walk_q    <= IO_W'(1);
            uo_q      <= '0;
            uio_out_q <= '0;
            uio_oe_q  <= '0;
        end else begin
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            clkdiv_q  <= clkdiv_d;
            walk_q    <= walk_d;
            uo_q      <= uo_d;
            uio_out_q <= uio_out_d;
            uio_oe_q  <= uio_oe_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = uio_out_q;
    assign uio_oe  = uio_oe_q;

endmodule

// File: tb/tb_tt_io_tester.sv
// tb/tb_tt_io_tester.sv - directed self-checking bench for tt_io_tester

module tb_tt_io_tester;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tt_io_tester #(
        .IO_W        (8),
        .CNT_W       (16),
        .SYNC_STAGES (2),
        .DIV_LOG2    (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] e_uo;
        logic [7:0] e_div;
        logic [7:0] e_par;

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        tick(2);
        check("rst_uo", uo_out, 8'h00);
        check("rst_uio", uio_out, 8'h00);
        check("rst_oe", uio_oe, 8'h00);

        // PASS: three-cycle latency, clkdiv period 8 starting from reset
        rst_n = 1'b1;
        ui_in = 8'h25;
        tick(2);
        check("pass_lat", uo_out, 8'h00);
        tick(1);
        check("pass_uo", uo_out, 8'h25);
        check("pass_oe", uio_oe, 8'h01);
        check("pass_div3", uio_out, 8'h00);
        for (int e = 4; e <= 20; e++) begin
            tick(1);
            e_div = ((e / 4) % 2 == 1) ? 8'h01 : 8'h00;
            check("pass_div", uio_out, e_div);
        end

        // COUNT: start, wrap into the high byte, reach 0x1234
        ui_in = 8'h40;
        tick(2);
        check("cnt_lat", uo_out, 8'h25);
        tick(1);
        check("cnt0_uo", uo_out, 8'h00);
        check("cnt0_hi", uio_out, 8'h00);
        check("cnt_oe", uio_oe, 8'hFF);
        tick(1);
        check("cnt1_uo", uo_out, 8'h01);
        tick(254);
        check("cnt255_uo", uo_out, 8'hFF);
        check("cnt255_hi", uio_out, 8'h00);
        tick(1);
        check("cnt256_uo", uo_out, 8'h00);
        check("cnt256_hi", uio_out, 8'h01);
        tick(44);
        check("cnt300_uo", uo_out, 8'h2C);
        check("cnt300_hi", uio_out, 8'h01);
        tick(4360);
        check("cnt1234_uo", uo_out, 8'h34);
        check("cnt1234_hi", uio_out, 8'h12);

        // Mode change mid-count: COUNT -> WALK -> COUNT restarts at zero
        ui_in = 8'hC0;
        tick(2);
        check("chg_still_uo", uo_out, 8'h36);
        check("chg_still_hi", uio_out, 8'h12);
        tick(1);
        check("chg_walk_uo", uo_out, 8'h01);
        check("chg_walk_oe", uio_oe, 8'h01);
        ui_in = 8'h40;
        tick(3);
        check("chg_cnt_uo", uo_out, 8'h00);
        check("chg_cnt_hi", uio_out, 8'h00);
        check("chg_cnt_oe", uio_oe, 8'hFF);
        tick(1);
        check("chg_cnt1_uo", uo_out, 8'h01);

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_uo", uo_out, 8'h00);
        check("arst_uio", uio_out, 8'h00);
        check("arst_oe", uio_oe, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        ui_in = 8'hC0;
        tick(1);
        check("arst_pass1_uo", uo_out, 8'h00);
        check("arst_pass1_oe", uio_oe, 8'h01);
        tick(1);
        check("arst_pass2_uo", uo_out, 8'h00);
        check("arst_pass2_oe", uio_oe, 8'h01);
        tick(1);

        // WALK: each bit held four cycles, clkdiv toggles with every step
        for (int k = 0; k <= 36; k++) begin
            if (k > 0) tick(1);
            e_uo  = 8'h01 << ((k / 4) % 8);
            e_div = ((k / 4) % 2 == 1) ? 8'h01 : 8'h00;
            check("walk_uo", uo_out, e_uo);
            check("walk_div", uio_out, e_div);
        end

        // ena low for 10 cycles freezes walker and clkdiv
        ena = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick(1);
            check("frz_uo", uo_out, 8'h02);
            check("frz_div", uio_out, 8'h01);
        end
        ena = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick(1);
            e_uo  = (j < 4) ? 8'h02 : 8'h04;
            e_div = (j < 4) ? 8'h01 : 8'h00;
            check("resume_uo", uo_out, e_uo);
            check("resume_div", uio_out, e_div);
        end

        // LOOP
        ui_in  = 8'h80;
        uio_in = 8'h5A;
        tick(2);
        check("loop_lat", uo_out, 8'h04);
        tick(1);
        check("loop_uo", uo_out, 8'h5A);
        check("loop_oe", uio_oe, 8'h00);
        check("loop_uio", uio_out, 8'h00);
        uio_in = 8'h07;
`ifdef TT_IO_TESTER_PARITY_EN
        e_par = 8'h87;
`else
        e_par = 8'h07;
`endif
        tick(2);
        check("loop07_lat", uo_out, 8'h5A);
        tick(1);
        check("loop07_uo", uo_out, e_par);
        uio_in = 8'hFF;
        tick(3);
        check("loopff_uo", uo_out, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
